// File: rtl/vga_pattern_sequencer.sv
// rtl/vga_pattern_sequencer.sv - frame-synchronous pattern/scroll sequencer for the VGA test-pattern datapath
//
// Purpose: once per frame (rising edge of vsync) update the pattern select
// and horizontal scroll offset according to the requested mode
// (AUTO / HOLD / MANUAL). Optional step-button debounce is enabled by
// defining the macro SEQ_DEBOUNCE_EN.
//
// Ports:
//   clk            in   pixel clock, only clock
//   reset          in   synchronous active-high reset
//   vsync          in   vertical sync; frame boundary is its rising edge
//   mode[1:0]      in   00 AUTO, 01 HOLD, 10 MANUAL, 11 treated as HOLD
//   speed[1:0]     in   scroll step per frame = 1 << speed
//   step           in   asynchronous manual-advance button, active-high
//   pattern_sel    out  current pattern index
//   scroll[9:0]    out  horizontal scroll offset
//   frame_tick     out  one-cycle pulse per frame boundary
//   pattern_change out  one-cycle pulse when pattern_sel changes

module vga_pattern_sequencer #(
   parameter int FRAMES_PER_PATTERN = 120,
   parameter int NUM_PATTERNS       = 4,
   parameter int DEBOUNCE_CYCLES    = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic [1:0] mode,
   input  logic [1:0] speed,
   input  logic       step,
   output logic [1:0] pattern_sel,
   output logic [9:0] scroll,
   output logic       frame_tick,
   output logic       pattern_change
);

   typedef enum logic [1:0] {
      ST_AUTO   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_MANUAL = 2'd2
   } state_t;

   localparam logic [9:0] FPP_LAST = 10'(FRAMES_PER_PATTERN - 1);
   localparam logic [1:0] PAT_LAST = 2'(NUM_PATTERNS - 1);

   state_t     state_q, state_d;
   logic       vs_q1, vs_q2;
   logic       st_q1, st_q2;
   logic [9:0] frame_cnt_q, frame_cnt_d;
   logic [9:0] scroll_q, scroll_d;
   logic [1:0] pattern_sel_q, pattern_sel_d;
   logic       frame_tick_q, frame_tick_d;
   logic       pattern_change_q, pattern_change_d;
   logic       pending_q, pending_d;

   logic       tick;
   logic       press;
   logic [9:0] step_amt;
   logic [1:0] next_pat;

   assign tick     = vs_q1 & ~vs_q2;
   assign step_amt = 10'd1 << speed;
   // Wrap explicitly so NUM_PATTERNS=1 keeps pattern_sel at 0.
   assign next_pat = (pattern_sel_q == PAT_LAST) ? 2'd0 : pattern_sel_q + 2'd1;

`ifdef SEQ_DEBOUNCE_EN
   localparam logic [15:0] DB_TARGET = 16'(DEBOUNCE_CYCLES);
   localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);

   logic [15:0] db_cnt_q, db_cnt_d;
   logic        press_q, press_d;

   // Counter saturates at the target so a held button fires only once;
   // it re-arms only when the synchronised step drops low.
   always_comb begin
      db_cnt_d = db_cnt_q;
      press_d  = 1'b0;
      if (!st_q2) begin
         db_cnt_d = 16'd0;
      end else if (db_cnt_q != DB_TARGET) begin
         db_cnt_d = db_cnt_q + 16'd1;
         press_d  = (db_cnt_q == DB_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt_q <= 16'd0;
         press_q  <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;
`else
   logic st_q3;

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q3 <= 1'b0;
      end else begin
         st_q3 <= st_q2;
      end
   end

   assign press = st_q2 & ~st_q3;
`endif

   // State register (plus all datapath flops and synchronisers).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_AUTO;
         vs_q1            <= 1'b0;
         vs_q2            <= 1'b0;
         st_q1            <= 1'b0;
         st_q2            <= 1'b0;
         frame_cnt_q      <= 10'd0;
         scroll_q         <= 10'd0;
         pattern_sel_q    <= 2'd0;
         frame_tick_q     <= 1'b0;
         pattern_change_q <= 1'b0;
         pending_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         vs_q1            <= vsync;
         vs_q2            <= vs_q1;
         st_q1            <= step;
         st_q2            <= st_q1;
         frame_cnt_q      <= frame_cnt_d;
         scroll_q         <= scroll_d;
         pattern_sel_q    <= pattern_sel_d;
         frame_tick_q     <= frame_tick_d;
         pattern_change_q <= pattern_change_d;
         pending_q        <= pending_d;
      end
   end

   // Next-state: mode is only sampled at a frame boundary.
   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (mode)
            2'b00:   state_d = ST_AUTO;
            2'b10:   state_d = ST_MANUAL;
            default: state_d = ST_HOLD;
         endcase
      end
   end

   // Outputs: the state chosen on a tick governs that same tick's update.
   always_comb begin
      frame_cnt_d      = frame_cnt_q;
      scroll_d         = scroll_q;
      pattern_sel_d    = pattern_sel_q;
      frame_tick_d     = tick;
      pattern_change_d = 1'b0;
      pending_d        = pending_q;

      if (tick) begin
         case (state_d)
            ST_AUTO: begin
               if (frame_cnt_q == FPP_LAST) begin
                  frame_cnt_d      = 10'd0;
                  pattern_sel_d    = next_pat;
                  scroll_d         = 10'd0;
                  pattern_change_d = 1'b1;
               end else begin
                  frame_cnt_d = frame_cnt_q + 10'd1;
                  scroll_d    = scroll_q + step_amt;
               end
            end
            ST_MANUAL: begin
               if (pending_q) begin
                  pattern_sel_d    = next_pat;
                  scroll_d         = 10'd0;
                  pattern_change_d = 1'b1;
               end else begin
                  scroll_d = scroll_q + step_amt;
               end
               // A press coinciding with the tick belongs to the next frame.
               pending_d = press;
            end
            default: begin
            end
         endcase
         if (state_d != ST_MANUAL) begin
            pending_d = 1'b0;
         end
      end else if (state_q == ST_MANUAL && press) begin
         pending_d = 1'b1;
      end
   end

   assign pattern_sel    = pattern_sel_q;
   assign scroll         = scroll_q;
   assign frame_tick     = frame_tick_q;
   assign pattern_change = pattern_change_q;

endmodule
